// File: rtl/player_input_decoder.sv
// player_input_decoder
//
// Turns a PS/2 scan-code set 2 byte stream into eight held-key action flags
// for the physics block. Keys are tracked as make/break state internally. The
// visible flags are a snapshot of that state taken only on the 60 Hz frame
// strobe, so each physics frame sees one consistent input set.
//
// Parameters:
//   SYNC_STAGES    - flop depth of the ps2_clk / ps2_data synchronizers (>= 2)
//   TIMEOUT_CYCLES - clk cycles without a ps2_clk fall before a partial frame is dropped
//
// Ports:
//   i_clk, i_rst             - system clock, async active-high reset
//   i_ps2_clk, i_ps2_data    - raw asynchronous PS/2 pins
//   i_en                     - one-cycle frame strobe (snapshot load)
//   o_p1_* / o_p2_*          - registered action flags
//   o_key_event              - one-cycle pulse when a mapped key changes held state
//   o_frame_err              - one-cycle pulse on start/parity/stop/timeout error
module player_input_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    input  logic i_en,
    output logic o_p1_move_left,
    output logic o_p1_move_right,
    output logic o_p1_jump,
    output logic o_p1_smash,
    output logic o_p2_move_left,
    output logic o_p2_move_right,
    output logic o_p2_jump,
    output logic o_p2_smash,
    output logic o_key_event,
    output logic o_frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Key index order: 0..3 = P1 left/right/jump/smash, 4..7 = P2 left/right/jump/smash
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;

    rx_state_e r_state,   w_state_d;
    logic [2:0] r_bit_cnt, w_bit_cnt_d;
    logic [7:0] r_shift,   w_shift_d;
    logic       r_parity,  w_parity_d;
    logic [TW-1:0] r_timeout, w_timeout_d;

    logic [7:0] r_key_state, w_key_state_d;
    logic       r_ext,       w_ext_d;
    logic       r_brk,       w_brk_d;
    logic       r_key_event, w_key_event_d;
    logic       r_frame_err;
    logic [7:0] r_out,       w_out_d;

    logic w_clk_s;
    logic w_data_s;
    logic w_fall;
    logic w_byte_ok;
    logic w_err;
    logic w_hit;
    logic [2:0] w_idx;

    // ---------------------------------------------------------------------
    // Synchronizers and falling-edge detect. Reset to the idle bus level so a
    // released reset with the pins high does not fake an edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

    // ---------------------------------------------------------------------
    // Frame receiver
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_timeout <= '0;
        end else begin
            r_state   <= w_state_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
            r_parity  <= w_parity_d;
            r_timeout <= w_timeout_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_parity_d  = r_parity;
        w_timeout_d = r_timeout;
        w_byte_ok   = 1'b0;
        w_err       = 1'b0;

        if (r_state == StIdle || w_fall) begin
            w_timeout_d = '0;
        end else begin
            w_timeout_d = r_timeout + TW'(1);
        end

        case (r_state)
            StIdle: begin
                if (w_fall) begin
                    if (!w_data_s) begin
                        w_state_d   = StData;
                        w_bit_cnt_d = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            StData: begin
                if (w_fall) begin
                    w_shift_d   = {w_data_s, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (w_fall) begin
                    w_parity_d = w_data_s;
                    w_state_d  = StStop;
                end
            end
            StStop: begin
                if (w_fall) begin
                    // Odd parity over data + parity bit, and stop bit must be 1.
                    if (w_data_s && (^{r_parity, r_shift})) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Abandon a stalled partial frame.
        if (r_state != StIdle && !w_fall && r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_d   = StIdle;
            w_timeout_d = '0;
            w_err       = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Scan-code decoder. At the stop bit r_shift holds the completed byte.
    // ---------------------------------------------------------------------
    always_comb begin
        w_hit = 1'b1;
        w_idx = 3'd0;
        case ({r_ext, r_shift})
            9'h01C:  w_idx = 3'd0;
            9'h023:  w_idx = 3'd1;
            9'h01D:  w_idx = 3'd2;
            9'h01B:  w_idx = 3'd3;
            9'h16B:  w_idx = 3'd4;
            9'h174:  w_idx = 3'd5;
            9'h175:  w_idx = 3'd6;
            9'h172:  w_idx = 3'd7;
            default: w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_key_state_d = r_key_state;
        w_ext_d       = r_ext;
        w_brk_d       = r_brk;
        w_key_event_d = 1'b0;

        if (w_err) begin
            w_ext_d = 1'b0;
            w_brk_d = 1'b0;
        end else if (w_byte_ok) begin
            if (r_shift == 8'hE0) begin
                w_ext_d = 1'b1;
            end else if (r_shift == 8'hF0) begin
                w_brk_d = 1'b1;
            end else begin
                // Only a real change of held state counts; typematic repeats
                // and orphan breaks fall through silently.
                if (w_hit && (r_key_state[w_idx] == r_brk)) begin
                    w_key_state_d[w_idx] = ~r_brk;
                    w_key_event_d        = 1'b1;
                end
                w_ext_d = 1'b0;
                w_brk_d = 1'b0;
            end
        end
    end

    // Snapshot: a held left+right pair cancels that player's movement.
    always_comb begin
        w_out_d = r_out;
        if (i_en) begin
            w_out_d = r_key_state;
            if (r_key_state[0] && r_key_state[1]) begin
                w_out_d[1:0] = 2'b00;
            end
            if (r_key_state[4] && r_key_state[5]) begin
                w_out_d[5:4] = 2'b00;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_state <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key_event <= 1'b0;
            r_frame_err <= 1'b0;
            r_out       <= '0;
        end else begin
            r_key_state <= w_key_state_d;
            r_ext       <= w_ext_d;
            r_brk       <= w_brk_d;
            r_key_event <= w_key_event_d;
            r_frame_err <= w_err;
            r_out       <= w_out_d;
        end
    end

    assign o_p1_move_left  = r_out[0];
    assign o_p1_move_right = r_out[1];
    assign o_p1_jump       = r_out[2];
    assign o_p1_smash      = r_out[3];
    assign o_p2_move_left  = r_out[4];
    assign o_p2_move_right = r_out[5];
    assign o_p2_jump       = r_out[6];
    assign o_p2_smash      = r_out[7];
    assign o_key_event     = r_key_event;
    assign o_frame_err     = r_frame_err;

endmodule

// File: tb/tb_player_input_decoder.sv
// Scoreboard bench for player_input_decoder: stimulus pushes expected
// observations, a negedge monitor pops and compares them.
module tb_player_input_decoder;

    localparam int unsigned SYNC    = 2;
    localparam int unsigned TO      = 200;
    localparam int          HALF    = 8;
    localparam int          EV_OUT  = 0;
    localparam int          EV_KEY  = 1;
    localparam int          EV_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic en;
    logic p1l, p1r, p1j, p1s, p2l, p2r, p2j, p2s;
    logic key_event, frame_err;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t exp_q[$];
    logic en_q = 1'b0;
    logic [7:0] prev_out = 8'h00;
    logic [7:0] out_vec;

    // Reference model: held keys and prefix flags.
    bit [7:0] m_held;
    bit       m_ext;
    bit       m_brk;

    player_input_decoder #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ps2_clk       (ps2_clk),
        .i_ps2_data      (ps2_data),
        .i_en            (en),
        .o_p1_move_left  (p1l),
        .o_p1_move_right (p1r),
        .o_p1_jump       (p1j),
        .o_p1_smash      (p1s),
        .o_p2_move_left  (p2l),
        .o_p2_move_right (p2r),
        .o_p2_jump       (p2j),
        .o_p2_smash      (p2s),
        .o_key_event     (key_event),
        .o_frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    assign out_vec = {p2s, p2j, p2r, p2l, p1s, p1j, p1r, p1l};

    // ---------------- model ----------------
    function automatic int map_code(input bit ext, input bit [7:0] b);
        if (!ext) begin
            if (b == 8'h1C) return 0;
            if (b == 8'h23) return 1;
            if (b == 8'h1D) return 2;
            if (b == 8'h1B) return 3;
        end else begin
            if (b == 8'h6B) return 4;
            if (b == 8'h74) return 5;
            if (b == 8'h75) return 6;
            if (b == 8'h72) return 7;
        end
        return -1;
    endfunction

    function automatic logic [7:0] snap();
        logic [7:0] s;
        s = m_held;
        if (s[0] && s[1]) s[1:0] = 2'b00;
        if (s[4] && s[5]) s[5:4] = 2'b00;
        return s;
    endfunction

    task automatic push(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input bit [7:0] b);
        int idx;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            idx = map_code(m_ext, b);
            if (idx >= 0 && m_held[idx] != !m_brk) begin
                m_held[idx] = !m_brk;
                push(EV_KEY, 8'h00);
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        push(EV_ERR, 8'h00);
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // ---------------- drivers ----------------
    // One PS/2 bit: data settles during clock-high, then a low phase. With
    // collide set, en is raised exactly in the cycle the DUT acts on this fall.
    task automatic ps2_bit(input bit d, input bit collide);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            if (collide && i == SYNC - 1) en = 1'b1;
            else if (collide && i == SYNC) en = 1'b0;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit collide);
        bit par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        if (collide) push(EV_OUT, snap());
        if (bad_par || bad_stop) model_err();
        else model_byte(b);
        ps2_bit(!bad_stop, collide);
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send(input bit [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_en();
        push(EV_OUT, snap());
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_err();
        model_err();
        ps2_bit(1'b1, 1'b0);
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic timeout_frame();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0);
        model_err();
        repeat (TO + 40) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) en_q <= en;

    task automatic check(input int kind, input logic [7:0] val, input string name);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected observation kind=%0d val=%02h, none expected",
                     name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_fail++;
                $display("FAIL %s: got kind=%0d val=%02h, want kind=%0d val=%02h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (en_q) check(EV_OUT, out_vec, "snapshot");
            if (key_event) check(EV_KEY, 8'h00, "key_event");
            if (frame_err) check(EV_ERR, 8'h00, "frame_err");
            if (!en_q) begin
                n_cmp++;
                if (out_vec !== prev_out) begin
                    n_fail++;
                    $display("FAIL hold: outputs %02h changed without en, want %02h",
                             out_vec, prev_out);
                end
            end
        end
        prev_out = out_vec;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check_const(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h want %02h", name, got, want);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1D, 8'h1B,
                                8'h6B, 8'h74, 8'h75, 8'h72, 8'hE0, 8'hF0};
        bit [7:0] b;
        int r;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; en = 1'b0;
        m_held = '0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_const("reset_outputs", out_vec, 8'h00);
        check_const("reset_key_event", {7'd0, key_event}, 8'h00);
        check_const("reset_frame_err", {7'd0, frame_err}, 8'h00);

        // Press / release A
        send(8'h1C); pulse_en();
        send(8'hF0); send(8'h1C); pulse_en();
        // Right arrow
        send(8'hE0); send(8'h74); pulse_en();
        send(8'hE0); send(8'hF0); send(8'h74); pulse_en();
        // Bad parity then good
        send_frame(8'h1D, 1'b1, 1'b0, 1'b0); pulse_en();
        send(8'h1D); pulse_en();
        // Typematic repeat
        send(8'h1D);
        // Direction conflict
        send(8'h1C); send(8'h23); pulse_en();
        send(8'hF0); send(8'h1C); pulse_en();
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h1D);
        // Orphan break and unmapped extended P1 code
        send(8'hF0); send(8'h1B); send(8'hE0); send(8'h1C); pulse_en();
        // Timeout then good frame
        timeout_frame();
        send(8'h1B); pulse_en();
        send(8'hF0); send(8'h1B);
        // Snapshot hold and same-cycle collision
        send(8'h1C);
        repeat (1000) @(negedge clk);
        send(8'hF0); send(8'h1C); pulse_en();
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        pulse_en();
        // Start and stop errors; error clears a pending prefix
        start_err();
        send(8'hE0); send_frame(8'h74, 1'b0, 1'b1, 1'b0);
        send(8'h74); pulse_en();

        // Reset mid-frame with a pending extended prefix
        send(8'hE0);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        rst = 1'b1;
        m_held = '0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_const("midframe_reset", out_vec, 8'h00);
        send(8'h74); pulse_en();

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 11)];
            if (r < 5)       send_frame(b, 1'b1, 1'b0, 1'b0);
            else if (r < 8)  send_frame(b, 1'b0, 1'b1, 1'b0);
            else if (r < 10) start_err();
            else if (r < 14) send_frame(b, 1'b0, 1'b0, 1'b1);
            else if (r < 32) pulse_en();
            else             send(b);
        end
        pulse_en();

        repeat (50) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected observations never seen, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/player_input_decoder.md
# player_input_decoder

Converts the PS/2 keyboard serial stream into the eight held-key action flags consumed by the physics block: p1_move_left, p1_move_right, p1_jump, p1_smash, p2_move_left, p2_move_right, p2_jump, p2_smash. It sits between the board's PS/2 pins and the physics inputs. It receives scan-code set 2 frames, tracks make/break state per key, and presents a stable snapshot that changes only on the 60 Hz frame strobe. This ensures that one physics frame always sees one consistent input set.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the ps2_clk/ps2_data synchronizers (≥2)
- TIMEOUT_CYCLES, 100000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- en  in  1  60 Hz frame strobe, one clk wide; same strobe that drives physics
- p1_move_left, p1_move_right, p1_jump, p1_smash  out  1 each  P1 action flags, registered
- p2_move_left, p2_move_right, p2_jump, p2_smash  out  1 each  P2 action flags, registered
- key_event  out  1  one-cycle pulse when a mapped key changes held state
- frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error

## Operation
- Synchronizers: ps2_clk and ps2_data each pass through SYNC_STAGES flops.
- Falling-edge detect: a falling edge is synced ps2_clk going 1→0 across consecutive cycles.
- Receiver FSM states: IDLE, DATA, PARITY, STOP. All sampling uses synced ps2_data at the detected falling edge.
  - IDLE: on a fall with data=0 (start bit), go to DATA with bit count 0. On a fall with data=1, stay IDLE and pulse frame_err.
  - DATA: shift 8 bits in, LSB first. After bit 7, go to PARITY.
  - PARITY: store the bit. Go to STOP.
  - STOP: byte is good when stop=1 and the 9 bits (data + parity) contain an odd number of 1s. Otherwise pulse frame_err and discard the byte. Return to IDLE in both cases.
  - Timeout: in any state other than IDLE, if no fall occurs for TIMEOUT_CYCLES cycles, go to IDLE and pulse frame_err. The counter clears on every fall and while in IDLE.
- Code decoder: acts on each good byte, using prefix flags ext and brk.
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte: look up {ext, byte}. On a match, key_state[idx] <= ~brk. Then clear ext and brk.
  - A frame_err clears ext and brk.
- Key map (scan-code set 2):
  - P1: 1C left, 23 right, 1D jump, 1B smash (non-extended only).
  - P2: E0 6B left, E0 74 right, E0 75 jump, E0 72 smash (extended only).
  - Non-extended 6B/74/75/72 and extended 1C/23/1D/1B are unmapped.
- Unmapped codes: leave key_state unchanged and clear the prefixes.
- Typematic repeats: a repeated make of an already-held key leaves key_state unchanged and produces no key_event.
- key_event pulses only when a key_state bit actually toggles.
- Output snapshot: on a cycle with en=1, every output register loads from key_state. With en=0, outputs hold.
- Direction conflict: if a player's left and right keys are both held, both of that player's move outputs load 0. Jump and smash pass straight through.

## Timing
- Reset: all outputs 0, key_state 0, ext=brk=0, FSM in IDLE, timeout counter 0, shift register 0. A reset mid-frame discards the partial byte.
- Edge latency: a ps2_clk fall on the pin is detected SYNC_STAGES+1 clk cycles later.
- key_state update: key_state and key_event change 1 cycle after the stop-bit fall is detected. frame_err asserts in that same cycle on error.
- Output latency: outputs reflect key_state on the clk edge where en=1. Worst case is one frame period after the key_state update.
- Same-cycle collision: if en=1 in the same cycle key_state updates, outputs take the pre-update key_state. The new value appears at the next en.
- Break with no prior make: key_state bit stays 0 and no key_event pulses.
- E0 F0 sequence: both prefixes are held until the code byte arrives.

## Test plan
- Press A: send 0x1C, then pulse en → p1_move_left=1 and one key_event. Release: send F0 1C, then en → p1_move_left=0.
- Press Right arrow: send E0 74, then en → p2_move_right=1 and p1_move_right=0. Release: send E0 F0 74, then en → p2_move_right=0.
- Bad parity: send 0x1D with even parity → one frame_err pulse, no key_event, p1_jump stays 0 after en. A following good 0x1D followed by en → p1_jump=1.
- Direction conflict: send 1C then 23, then en → p1_move_left=0 and p1_move_right=0. Then send F0 1C, then en → p1_move_right=1.
- Timeout: stop ps2_clk after 5 data bits and wait TIMEOUT_CYCLES → frame_err pulses and the FSM returns to IDLE. A following good 0x1B followed by en → p1_smash=1.
- Snapshot hold: send 0x1C with en held 0 for 1000 cycles → outputs stay 0. Pulse en in the same cycle as the key_state update → output stays 0. The next en → p1_move_left=1.
